// File: rtl/heartbeat_scheduler_if.sv
// Control and status bundle between the heartbeat scheduler and its neighbours
// (button debouncer, LED clock divider).
interface heartbeat_scheduler_if;
  logic       en;
  logic       mode_btn;
  logic       div_clk;
  logic [1:0] period;
  logic [1:0] mode;
  logic       update_pending;
  logic       step_strobe;

  modport master (
    output en, mode_btn, div_clk,
    input  period, mode, update_pending, step_strobe
  );

  modport slave (
    input  en, mode_btn, div_clk,
    output period, mode, update_pending, step_strobe
  );
endinterface

// File: rtl/heartbeat_scheduler.sv
// Steps the LED divider period select through sweep / ping-pong / heartbeat tables,
// deferring every period change to a divider output edge.
module heartbeat_scheduler #(
  parameter int unsigned CLK_FREQ = 32'd12_000_000,
  parameter int unsigned DWELL_MS = 32'd250
) (
  input logic                  clk,
  input logic                  rst_n,
  heartbeat_scheduler_if.slave hb
);

  localparam int unsigned DWELL_CYC  = CLK_FREQ / 32'd1000 * DWELL_MS;
  localparam logic [31:0] DWELL_LAST = DWELL_CYC - 32'd1;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    SWEEP_UP  = 2'd1,
    PINGPONG  = 2'd2,
    HEARTBEAT = 2'd3
  } mode_e;

  mode_e       mode_r, mode_n;
  logic [31:0] dwell_r, dwell_n;
  logic [2:0]  idx_r, idx_n;
  logic [1:0]  pend_r, pend_n;
  logic        pending_r, pending_n;
  logic [1:0]  period_r, period_n;
  logic        strobe_r, strobe_n;
  logic        div_q_r, div_q_n;

  logic        div_edge_s;
  logic        counting_s;
  logic        terminal_s;
  logic [2:0]  next_idx_s;

  function automatic logic [1:0] step_value(input mode_e m, input logic [2:0] idx);
    logic [1:0] v;
    v = 2'd0;
    case (m)
      SWEEP_UP:  v = idx[1:0];
      PINGPONG: begin
        case (idx)
          3'd0:    v = 2'd0;
          3'd1:    v = 2'd1;
          3'd2:    v = 2'd2;
          3'd3:    v = 2'd3;
          3'd4:    v = 2'd2;
          3'd5:    v = 2'd1;
          default: v = 2'd0;
        endcase
      end
      HEARTBEAT: begin
        case (idx[1:0])
          2'd0:    v = 2'd0;
          2'd1:    v = 2'd1;
          2'd2:    v = 2'd0;
          2'd3:    v = 2'd3;
          default: v = 2'd0;
        endcase
      end
      default:   v = 2'd0;
    endcase
    return v;
  endfunction

  assign div_edge_s = hb.div_clk ^ div_q_r;
  assign counting_s = hb.en && (mode_r != HOLD);
  assign terminal_s = counting_s && (dwell_r == DWELL_LAST);
  assign next_idx_s = (idx_r == ((mode_r == PINGPONG) ? 3'd5 : 3'd3)) ? 3'd0 : idx_r + 3'd1;

  // Next-state: apply on divider edge first, then mode button (which beats a dwell terminal).
  always_comb begin
    div_q_n   = hb.div_clk;
    mode_n    = mode_r;
    dwell_n   = dwell_r;
    idx_n     = idx_r;
    pend_n    = pend_r;
    pending_n = pending_r;
    period_n  = period_r;
    strobe_n  = 1'b0;

    if (div_edge_s && pending_r) begin
      period_n  = pend_r;
      pending_n = 1'b0;
      strobe_n  = 1'b1;
    end else begin
      period_n  = period_r;
    end

    if (hb.mode_btn) begin
      mode_n  = mode_e'(mode_r + 2'd1);
      dwell_n = 32'd0;
      idx_n   = 3'd0;
      if (mode_n != HOLD) begin
        pend_n    = 2'd0;
        pending_n = 1'b1;
      end else begin
        pending_n = 1'b0;
      end
    end else if (terminal_s) begin
      dwell_n   = 32'd0;
      idx_n     = next_idx_s;
      pend_n    = step_value(mode_r, next_idx_s);
      pending_n = 1'b1;
    end else if (counting_s) begin
      dwell_n = dwell_r + 32'd1;
    end else begin
      dwell_n = dwell_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r    <= HOLD;
      dwell_r   <= 32'd0;
      idx_r     <= 3'd0;
      pend_r    <= 2'd0;
      pending_r <= 1'b0;
      period_r  <= 2'd0;
      strobe_r  <= 1'b0;
      div_q_r   <= 1'b0;
    end else begin
      mode_r    <= mode_n;
      dwell_r   <= dwell_n;
      idx_r     <= idx_n;
      pend_r    <= pend_n;
      pending_r <= pending_n;
      period_r  <= period_n;
      strobe_r  <= strobe_n;
      div_q_r   <= div_q_n;
    end
  end

  assign hb.period         = period_r;
  assign hb.mode           = mode_r;
  assign hb.update_pending = pending_r;
  assign hb.step_strobe    = strobe_r;

endmodule

// File: tb/tb_heartbeat_scheduler.sv
// Directed bench: expected (period, cycle) pairs are queued as stimulus is issued and
// checked by a monitor whenever step_strobe is seen; DWELL_CYC = 12.
module tb_heartbeat_scheduler;

  logic clk = 1'b0;
  logic rst_n;

  heartbeat_scheduler_if hb_if ();

  heartbeat_scheduler #(
    .CLK_FREQ (32'd12_000),
    .DWELL_MS (32'd1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hb    (hb_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] period;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] p, input int c);
    exp_t e;
    e.period = p;
    e.cyc    = c;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(output int p);
    hb_if.mode_btn = 1'b1;
    p = cyc + 1;
    tick();
    hb_if.mode_btn = 1'b0;
  endtask

  task automatic run(input int n, input int div_per);
    for (int j = 1; j <= n; j++) begin
      if (div_per > 0 && (j % div_per) == 0) hb_if.div_clk = ~hb_if.div_clk;
      tick();
    end
  endtask

  // Scoreboard monitor: every strobe must match the next queued period and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && hb_if.step_strobe !== 1'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 32'(hb_if.step_strobe), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("step_period", 32'(hb_if.period), 32'(e.period));
        check("step_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int p;
    rst_n          = 1'b0;
    hb_if.en       = 1'b1;
    hb_if.mode_btn = 1'b1;
    hb_if.div_clk  = 1'b0;

    // Test 1: reset with mode_btn held and div_clk toggling
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_period",  32'(hb_if.period), 32'd0);
      check("rst_mode",    32'(hb_if.mode), 32'd0);
      check("rst_pending", 32'(hb_if.update_pending), 32'd0);
      check("rst_strobe",  32'(hb_if.step_strobe), 32'd0);
      hb_if.div_clk = ~hb_if.div_clk;
    end
    rst_n          = 1'b1;
    hb_if.mode_btn = 1'b0;
    tick();
    check("post_rst_mode",    32'(hb_if.mode), 32'd0);
    check("post_rst_pending", 32'(hb_if.update_pending), 32'd0);

    // Test 2: SWEEP_UP, edges every 5 clks, terminals every 12
    press(p);
    check("mode_sweep", 32'(hb_if.mode), 32'd1);
    push(2'd0, p + 5);  push(2'd1, p + 15); push(2'd2, p + 25);
    push(2'd3, p + 40); push(2'd0, p + 50);
    run(55, 5);

    // Test 3: PINGPONG for 8 dwells; terminal at +60 coincides with an idle edge
    press(p);
    check("mode_pingpong", 32'(hb_if.mode), 32'd2);
    push(2'd0, p + 5);  push(2'd1, p + 15); push(2'd2, p + 25); push(2'd3, p + 40);
    push(2'd2, p + 50); push(2'd1, p + 65); push(2'd0, p + 75); push(2'd1, p + 85);
    run(89, 5);

    // Test 4: HEARTBEAT with div_clk static; latest pending value wins
    press(p);
    check("mode_heartbeat", 32'(hb_if.mode), 32'd3);
    run(30, 0);
    check("static_pending", 32'(hb_if.update_pending), 32'd1);
    check("static_period",  32'(hb_if.period), 32'd1);
    run(7, 0);
    push(2'd3, p + 38);
    run(1, 1);
    check("hb_cleared", 32'(hb_if.update_pending), 32'd0);

    // Test 5: mode_btn on the dwell terminal cycle (p+48) enters HOLD, no step
    run(9, 0);
    press(p);
    check("btn_term_mode",    32'(hb_if.mode), 32'd0);
    check("btn_term_pending", 32'(hb_if.update_pending), 32'd0);
    check("btn_term_period",  32'(hb_if.period), 32'd3);
    run(20, 2);
    check("hold_period", 32'(hb_if.period), 32'd3);

    // Test 6: en=0 for 20 clks at dwell_cnt=7; pending still applies meanwhile
    press(p);
    check("mode_sweep2", 32'(hb_if.mode), 32'd1);
    run(7, 0);
    hb_if.en = 1'b0;
    run(2, 0);
    push(2'd0, p + 10);
    run(1, 1);
    run(17, 0);
    check("frozen_period",  32'(hb_if.period), 32'd0);
    check("frozen_pending", 32'(hb_if.update_pending), 32'd0);
    hb_if.en = 1'b1;
    push(2'd1, p + 33);
    run(6, 1);
    run(4, 0);

    // Reset with an update pending
    press(p);
    check("pre_rst_pending", 32'(hb_if.update_pending), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_period",  32'(hb_if.period), 32'd0);
    check("mid_rst_mode",    32'(hb_if.mode), 32'd0);
    check("mid_rst_pending", 32'(hb_if.update_pending), 32'd0);
    check("mid_rst_strobe",  32'(hb_if.step_strobe), 32'd0);
    rst_n = 1'b1;
    run(3, 1);
    check("after_rst_period", 32'(hb_if.period), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
